// File: rtl/aes_pkg.sv
// Shared AES definitions for the 8-bit datapath core.
// State width, stage FSM encoding and ShiftRows index helper.
package aes_pkg;

  localparam int AES_NB = 16;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } subshift_state_t;

  // Output byte 4c+r comes from column (c+r) mod 4, same row.
  function automatic logic [3:0] shift_idx(input logic [3:0] rcnt);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] sc;
    r  = rcnt[1:0];
    c  = rcnt[3:2];
    sc = c + r;
    return {sc, r};
  endfunction

endpackage

// File: rtl/aes_subshift_stage_sbox.sv
// AES forward S-box, purely combinational.
// Table is stored with entry 0x00 in the most significant byte.
module aes_subshift_stage_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0]  ia;
  logic [10:0] bit_idx;

  assign ia      = ~a;
  assign bit_idx = {ia, 3'b000};
  assign y       = TABLE[bit_idx +: 8];

endmodule

// File: rtl/aes_subshift_stage.sv
// Byte-serial SubBytes + ShiftRows stage.
// Fills a 16-byte buffer with substituted bytes, then drains it row-shifted.
import aes_pkg::*;

module aes_subshift_stage #(
  parameter int NB = AES_NB
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       clear,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  subshift_state_t state;
  logic [3:0]      wcnt;
  logic [3:0]      rcnt;
  logic [7:0]      sbuf [NB];
  logic [7:0]      sub;
  logic            in_acc;
  logic            out_xfer;

  aes_subshift_stage_sbox S_box (
    .a (in_data),
    .y (sub)
  );

  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign in_acc    = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign out_last  = out_valid & (rcnt == 4'd15);
  assign out_data  = sbuf[shift_idx(rcnt)];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= FILL;
      wcnt  <= 4'd0;
      rcnt  <= 4'd0;
    end else if (clear) begin
      state <= FILL;
      wcnt  <= 4'd0;
      rcnt  <= 4'd0;
    end else begin
      unique case (state)
        FILL: begin
          if (in_acc) begin
            wcnt <= wcnt + 4'd1;
            if (wcnt == 4'd15) begin
              state <= DRAIN;
              rcnt  <= 4'd0;
            end
          end
        end
        DRAIN: begin
          if (out_xfer) begin
            rcnt <= rcnt + 4'd1;
            if (rcnt == 4'd15) state <= FILL;
          end
        end
      endcase
    end
  end

  // Data buffer needs no reset; every slot is rewritten before it is read.
  always_ff @(posedge HCLK) begin
    if (!clear && in_acc) sbuf[wcnt] <= sub;
  end

endmodule

// File: tb/tb_aes_subshift_stage.sv
// Directed and backpressure bench for aes_subshift_stage.
// Reference S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_subshift_stage;

  typedef logic [7:0] blk_t [16];

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] sbt [256];

  aes_subshift_stage dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
               ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic blk_t model(input blk_t b);
    blk_t m;
    for (int k = 0; k < 16; k++) begin
      int r, c, src;
      r = k % 4;
      c = k / 4;
      src = 4 * ((c + r) % 4) + r;
      m[k] = sbt[b[src]];
    end
    return m;
  endfunction

  // Streams one block in and out; rnd randomises valid/ready.
  task automatic xfer_block(input blk_t blk, input blk_t expv,
                            input bit rnd, output int cycles);
    int         ip;
    int         op;
    bit         stalled;
    logic [7:0] held;
    ip = 0;
    op = 0;
    stalled = 0;
    held = 8'h00;
    cycles = 0;
    while (op < 16 && cycles < 2000) begin
      @(negedge HCLK);
      clear = 1'b0;
      in_valid = (ip < 16) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      in_data = in_valid ? blk[ip] : 8'($urandom);
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held);
      end
      if (in_valid && in_ready) ip++;
      if (out_valid && out_ready) begin
        chk($sformatf("data%0d", op), out_data, expv[op]);
        chk($sformatf("last%0d", op), out_last, op == 15);
        op++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
      cycles++;
    end
    if (op < 16) chk("timeout", op, 16);
    chk("in_count", ip, 16);
    in_valid = 1'b0;
  endtask

  task automatic fill_block(input blk_t blk);
    for (int i = 0; i < 16; i++) begin
      @(negedge HCLK);
      in_valid = 1'b1;
      in_data = blk[i];
      out_ready = 1'b0;
    end
    @(negedge HCLK);
    in_valid = 1'b0;
  endtask

  // Drains nine bytes, then stalls with rcnt at 9.
  task automatic drain_to_nine(input blk_t expv);
    for (int i = 0; i < 9; i++) begin
      chk("pre_valid", out_valid, 1);
      chk($sformatf("pre_data%0d", i), out_data, expv[i]);
      out_ready = 1'b1;
      @(negedge HCLK);
    end
    out_ready = 1'b0;
    @(negedge HCLK);
    chk("stall9_valid", out_valid, 1);
    chk("stall9_data", out_data, expv[9]);
  endtask

  initial begin
    blk_t fips_in, fips_out, zero_in, sixty3, seq_in, seq_out, a, b;
    int cyc;
    int tot;

    for (int i = 0; i < 256; i++) sbt[i] = sbox_calc(8'(i));

    fips_in  = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b,
                 8'h9a, 8'hc6, 8'h8d, 8'h2a, 8'he9, 8'hf8, 8'h48, 8'h08};
    fips_out = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                 8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
    seq_out  = '{8'h63, 8'h6b, 8'h67, 8'h76, 8'hf2, 8'h01, 8'hab, 8'h7b,
                 8'h30, 8'hd7, 8'h77, 8'hc5, 8'hfe, 8'h7c, 8'h6f, 8'h2b};
    for (int i = 0; i < 16; i++) begin
      zero_in[i] = 8'h00;
      sixty3[i]  = 8'h63;
      seq_in[i]  = 8'(i);
    end

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    xfer_block(fips_in, fips_out, 0, cyc);
    chk("fips_cycles", cyc, 32);
    xfer_block(zero_in, sixty3, 0, cyc);
    xfer_block(seq_in, seq_out, 0, cyc);

    tot = 0;
    for (int k = 0; k < 3; k++) begin
      xfer_block(fips_in, fips_out, 0, cyc);
      tot += cyc;
    end
    chk("throughput96", tot, 96);

    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 16; i++) a[i] = 8'($urandom);
      xfer_block(a, model(a), 1, cyc);
    end

    // Clear mid-fill: 7 bytes taken, 8th dropped by clear.
    for (int i = 0; i < 16; i++) a[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge HCLK);
      in_valid = 1'b1;
      in_data = a[i];
      out_ready = 1'b1;
      clear = (i == 7);
    end
    @(negedge HCLK);
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clrf_in_ready", in_ready, 1);
    chk("clrf_out_valid", out_valid, 0);
    b = seq_in;
    xfer_block(b, seq_out, 0, cyc);
    chk("clrf_cycles", cyc, 32);

    // Clear mid-drain with stall at rcnt 9.
    fill_block(fips_in);
    drain_to_nine(fips_out);
    clear = 1'b1;
    @(negedge HCLK);
    clear = 1'b0;
    chk("clrd_out_valid", out_valid, 0);
    chk("clrd_in_ready", in_ready, 1);
    chk("clrd_out_last", out_last, 0);
    xfer_block(zero_in, sixty3, 0, cyc);
    chk("clrd_cycles", cyc, 32);

    // Async reset mid-drain, asserted between edges.
    fill_block(seq_in);
    drain_to_nine(seq_out);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_last", out_last, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    xfer_block(fips_in, fips_out, 0, cyc);
    chk("arst_cycles", cyc, 32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
